func_sweep_checker: RTL and testbench
=====================================

Name: func_sweep_checker

Overview:
- Sequencer/checker that sits directly upstream and downstream of the 3-input function decoder stage.
- Drives the decoder's 3-bit input through all 8 codes (0..7), waits a programmable settle time, then samples the f1/f2/f3 outputs.
- Builds a captured truth table, compares it bit-by-bit against expected minterm masks, and reports pass/fail with error statistics.
- Used for on-board self-test of the function-decoder path.

Parameters:
- SETTLE_CYCLES, 1, idle cycles after each new inp_o before sampling; range 0..15.
- EXP_F1, 8'h94, expected f1 truth table; bit i = output for inp = i (minterms 2,4,7).
- EXP_F2, 8'h09, expected f2 truth table (minterms 0,3).
- EXP_F3, 8'h9D, expected f3 truth table (minterms 0,2,3,4,7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- inp_o  out  3  code driven to the decoder's inp.
- f1_i  in  1  decoder f1, combinational from inp_o.
- f2_i  in  1  decoder f2.
- f3_i  in  1  decoder f3.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  high when the last sweep had zero mismatches; held until next start.
- tt_f1  out  8  captured f1 truth table.
- tt_f2  out  8  captured f2 truth table.
- tt_f3  out  8  captured f3 truth table.
- err_count  out  5  total mismatched bits, range 0..24.
- first_err_valid  out  1  at least one mismatch seen.
- first_err_idx  out  3  inp code of the first mismatch.

Behaviour:
- Reset: rst_n low asynchronously forces IDLE. All outputs reset to 0: inp_o, busy, done, pass, tt_*, err_count, first_err_*. The settle counter and idx also clear to 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0; inp_o holds 0.
  - start=1 → SETTLE. On that same edge: idx=0, settle counter=SETTLE_CYCLES; clear tt_*, err_count, first_err_*, pass.
- SETTLE:
  - busy=1; inp_o=idx.
  - Decrement the counter each cycle; at 0 → SAMPLE.
  - SETTLE_CYCLES=0 skips SETTLE: IDLE goes straight to SAMPLE.
- SAMPLE (one cycle):
  - Write f1_i/f2_i/f3_i into bit idx of tt_f1/tt_f2/tt_f3.
  - Add the number of mismatches vs EXP_*[idx] (0..3) to err_count.
  - On the first nonzero mismatch: set first_err_valid=1 and first_err_idx=idx.
  - If idx==7 → DONE; otherwise idx+1 → SETTLE with the counter reloaded.
- DONE (one cycle):
  - done=1, busy=0.
  - pass=1 iff err_count==0, including the count from the final sample.
  - Then → IDLE.
- Latency:
  - Start sampled at edge 0. Samples occur at edges k*(SETTLE_CYCLES+1), k=1..8.
  - done is high in the cycle after edge 8*(SETTLE_CYCLES+1)+1.
- Data path: f*_i are treated as combinational from inp_o, so there are no synchronizers. inp_o is registered and stable throughout SETTLE+SAMPLE for each idx.
- start while busy or in DONE: ignored, no restart, no extra done pulse.
- Reset mid-sweep: immediate abort. No done pulse; partial table discarded (zeroed).
- err_count saturates at 24, which cannot be exceeded by construction. idx never wraps past 7.
- Outputs tt_*, err_count, first_err_*, pass persist in IDLE until the next start.

Optional Feature:
- Macro: SWEEP_STOP_ON_ERR_EN.
- Defined: a SAMPLE with any mismatch → DONE immediately (pass=0). Untested tt bits remain 0; err_count reflects only that sample.
- Undefined: always sweep all 8 codes; err_count accumulates the full total.

Test Plan:
- Real decoder attached, SETTLE_CYCLES=1, pulse start → done pulse after edge 17; tt_f1=8'h94, tt_f2=8'h09, tt_f3=8'h9D, err_count=0, pass=1, first_err_valid=0.
- f2_i forced 0 → tt_f2=8'h00, err_count=2, first_err_valid=1, first_err_idx=0, pass=0.
- Hold start high through the whole sweep, or re-pulse it at cycle 5 → exactly one done pulse at the cycle above; results match scenario 1.
- Drop rst_n at cycle 9 mid-sweep → busy, inp_o, tt_* go 0 without waiting for clk, no done. Release rst_n and start again → normal pass result.
- SETTLE_CYCLES=0 → inp_o steps every cycle 0..7; done after edge 9; scenario-1 results.
- SWEEP_STOP_ON_ERR_EN defined, f1_i forced 1, SETTLE_CYCLES=1 → done after edge 3, err_count=1, first_err_idx=0, tt_f1=8'h01, pass=0.

Source files
------------

// File: rtl/func_sweep_checker.sv
// func_sweep_checker
//   Self-test sequencer/checker for the 3-input function decoder. It steps the
//   decoder input through codes 0..7 and waits SETTLE_CYCLES cycles at each code.
//   It then samples f1/f2/f3 into captured truth tables and compares each bit
//   against the EXP_* minterm masks. At the end of a sweep it reports pass/fail
//   and mismatch statistics.
//
//   Optional build macro: SWEEP_STOP_ON_ERR_EN
//     When defined, the sweep stops at the first sample that has any mismatch.
//
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     start               begin a sweep (only honoured in IDLE)
//     inp_o               code driven to the decoder input (registered)
//     f1_i, f2_i, f3_i    decoder outputs, combinational from inp_o
//     busy                high while sweeping (SETTLE/SAMPLE)
//     done                one-cycle pulse at the end of a sweep
//     pass                last sweep had zero mismatches; held until next start
//     tt_f1/tt_f2/tt_f3   captured truth tables (bit i = output for inp = i)
//     err_count           total mismatched bits (0..24)
//     first_err_valid     at least one mismatch seen
//     first_err_idx       inp code of the first mismatch
module func_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  EXP_F1        = 8'h94,
    parameter logic [7:0]  EXP_F2        = 8'h09,
    parameter logic [7:0]  EXP_F3        = 8'h9D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] inp_o,
    input  logic       f1_i,
    input  logic       f2_i,
    input  logic       f3_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt_f1,
    output logic [7:0] tt_f2,
    output logic [7:0] tt_f3,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [2:0] first_err_idx
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);
    localparam bit         SkipSettle = (SETTLE_CYCLES == 0);
    localparam logic [4:0] ErrMax     = 5'd24;

`ifdef SWEEP_STOP_ON_ERR_EN
    localparam bit StopOnErr = 1'b1;
`else
    localparam bit StopOnErr = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] inp_q, inp_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] tt_f1_q, tt_f1_d;
    logic [7:0] tt_f2_q, tt_f2_d;
    logic [7:0] tt_f3_q, tt_f3_d;
    logic [4:0] err_q, err_d;
    logic       fev_q, fev_d;
    logic [2:0] fei_q, fei_d;

    logic       mis_f1, mis_f2, mis_f3, any_mis;
    logic [1:0] mis_cnt;
    logic [4:0] err_sum;

    // Per-sample mismatch against the expected masks at the current code.
    always_comb begin
        mis_f1  = f1_i ^ EXP_F1[idx_q];
        mis_f2  = f2_i ^ EXP_F2[idx_q];
        mis_f3  = f3_i ^ EXP_F3[idx_q];
        any_mis = mis_f1 | mis_f2 | mis_f3;
        mis_cnt = {1'b0, mis_f1} + {1'b0, mis_f2} + {1'b0, mis_f3};
        err_sum = err_q + {3'b000, mis_cnt};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tt_f1_d = tt_f1_q;
        tt_f2_d = tt_f2_q;
        tt_f3_d = tt_f3_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fei_d   = fei_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = 3'd0;
                    cnt_d   = SettleLoad;
                    pass_d  = 1'b0;
                    tt_f1_d = 8'h00;
                    tt_f2_d = 8'h00;
                    tt_f3_d = 8'h00;
                    err_d   = 5'd0;
                    fev_d   = 1'b0;
                    fei_d   = 3'd0;
                    state_d = SkipSettle ? StSample : StSettle;
                end
            end
            StSettle: begin
                // Leave on the cycle the counter reaches zero, so SETTLE lasts
                // exactly SETTLE_CYCLES cycles.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                tt_f1_d[idx_q] = f1_i;
                tt_f2_d[idx_q] = f2_i;
                tt_f3_d[idx_q] = f3_i;
                err_d = (err_sum > ErrMax) ? ErrMax : err_sum;
                if (any_mis && !fev_q) begin
                    fev_d = 1'b1;
                    fei_d = idx_q;
                end
                if (idx_q == 3'd7 || (StopOnErr && any_mis)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = SettleLoad;
                    state_d = SkipSettle ? StSample : StSettle;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                pass_d  = (err_q == 5'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // busy and inp_o are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        busy_d = (state_d == StSettle) || (state_d == StSample);
        inp_d  = busy_d ? idx_d : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            inp_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_f1_q <= 8'h00;
            tt_f2_q <= 8'h00;
            tt_f3_q <= 8'h00;
            err_q   <= 5'd0;
            fev_q   <= 1'b0;
            fei_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            inp_q   <= inp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_f1_q <= tt_f1_d;
            tt_f2_q <= tt_f2_d;
            tt_f3_q <= tt_f3_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fei_q   <= fei_d;
        end
    end

    assign inp_o           = inp_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign tt_f1           = tt_f1_q;
    assign tt_f2           = tt_f2_q;
    assign tt_f3           = tt_f3_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_func_sweep_checker.sv
// Directed bench for func_sweep_checker: one instance with SETTLE_CYCLES=1
// (with fault-injection on the decoder model) and one with SETTLE_CYCLES=0.
module tb_func_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start1, start0;
    logic       force_f1_one, force_f2_zero;

    logic [2:0] inp1, inp0;
    logic       f1_1, f2_1, f3_1, f1_0, f2_0, f3_0;
    logic       busy1, done1, pass1, fev1;
    logic       busy0, done0, pass0, fev0;
    logic [7:0] tt1_f1, tt1_f2, tt1_f3, tt0_f1, tt0_f2, tt0_f3;
    logic [4:0] err1, err0;
    logic [2:0] fei1, fei0;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n;
    int pulses;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder: f1 = m(2,4,7), f2 = m(0,3), f3 = m(0,2,3,4,7).
    assign f1_1 = force_f1_one ? 1'b1 : (inp1 == 3'd2 || inp1 == 3'd4 || inp1 == 3'd7);
    assign f2_1 = force_f2_zero ? 1'b0 : (inp1 == 3'd0 || inp1 == 3'd3);
    assign f3_1 = (inp1 == 3'd0 || inp1 == 3'd2 || inp1 == 3'd3 || inp1 == 3'd4
                   || inp1 == 3'd7);
    assign f1_0 = (inp0 == 3'd2 || inp0 == 3'd4 || inp0 == 3'd7);
    assign f2_0 = (inp0 == 3'd0 || inp0 == 3'd3);
    assign f3_0 = (inp0 == 3'd0 || inp0 == 3'd2 || inp0 == 3'd3 || inp0 == 3'd4
                   || inp0 == 3'd7);

    func_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .inp_o(inp1),
        .f1_i(f1_1), .f2_i(f2_1), .f3_i(f3_1),
        .busy(busy1), .done(done1), .pass(pass1),
        .tt_f1(tt1_f1), .tt_f2(tt1_f2), .tt_f3(tt1_f3),
        .err_count(err1), .first_err_valid(fev1), .first_err_idx(fei1)
    );

    func_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .inp_o(inp0),
        .f1_i(f1_0), .f2_i(f2_0), .f3_i(f3_0),
        .busy(busy0), .done(done0), .pass(pass0),
        .tt_f1(tt0_f1), .tt_f2(tt0_f2), .tt_f3(tt0_f3),
        .err_count(err0), .first_err_valid(fev0), .first_err_idx(fei0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on the selected instance; the edge consumed here is edge 0.
    task automatic kick(input bit sel, input bit hold);
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            if (sel) start0 = 1'b0; else start1 = 1'b0;
        end
    endtask

    // Count edges until done (bounded); keep watching 3 more edges for extra pulses.
    task automatic wait_done(input bit sel, output int en, output int np);
        logic d;
        en = -1;
        np = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            d = sel ? done0 : done1;
            if (d) begin
                if (en < 0) en = n;
                np++;
                start1 = 1'b0;
                start0 = 1'b0;
            end
            if (en > 0 && n >= en + 3) break;
        end
    endtask

    task automatic check_res1(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input logic [4:0] ee, input logic ev,
                              input logic [2:0] ei, input logic ep);
        check({tag, "_tt_f1"}, 32'(tt1_f1), 32'(e1));
        check({tag, "_tt_f2"}, 32'(tt1_f2), 32'(e2));
        check({tag, "_tt_f3"}, 32'(tt1_f3), 32'(e3));
        check({tag, "_err"}, 32'(err1), 32'(ee));
        check({tag, "_fev"}, 32'(fev1), 32'(ev));
        check({tag, "_fei"}, 32'(fei1), 32'(ei));
        check({tag, "_pass"}, 32'(pass1), 32'(ep));
        check({tag, "_busy_idle"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start1        = 1'b0;
        start0        = 1'b0;
        force_f1_one  = 1'b0;
        force_f2_zero = 1'b0;
        #3;
        check("rst_inp", 32'(inp1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pass", 32'(pass1), 32'd0);
        check("rst_tt", 32'({tt1_f1, tt1_f2, tt1_f3}), 32'd0);
        check("rst_err", 32'({err1, fev1, fei1}), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Scenario 1: healthy decoder, SETTLE_CYCLES=1.
        kick(1'b0, 1'b0);
        check("s1_busy_e0", 32'(busy1), 32'd1);
        check("s1_inp_e0", 32'(inp1), 32'd0);
        @(posedge clk); #1;
        check("s1_inp_e1", 32'(inp1), 32'd0);
        @(posedge clk); #1;
        check("s1_inp_e2", 32'(inp1), 32'd1);
        check("s1_tt_f3_e2", 32'(tt1_f3), 32'h01);
        wait_done(1'b0, edge_n, pulses);
        check("s1_done_edge", 32'(edge_n + 2), 32'd17);
        check("s1_pulses", 32'(pulses), 32'd1);
        check_res1("s1", 8'h94, 8'h09, 8'h9D, 5'd0, 1'b0, 3'd0, 1'b1);

        // Scenario 2: f2 stuck at 0.
        force_f2_zero = 1'b1;
        kick(1'b0, 1'b0);
        wait_done(1'b0, edge_n, pulses);
`ifdef SWEEP_STOP_ON_ERR_EN
        check("s2_done_edge", 32'(edge_n), 32'd3);
        check_res1("s2", 8'h00, 8'h00, 8'h01, 5'd1, 1'b1, 3'd0, 1'b0);
`else
        check("s2_done_edge", 32'(edge_n), 32'd17);
        check_res1("s2", 8'h94, 8'h00, 8'h9D, 5'd2, 1'b1, 3'd0, 1'b0);
`endif
        force_f2_zero = 1'b0;

        // Scenario 3a: start held high through the sweep.
        kick(1'b0, 1'b1);
        wait_done(1'b0, edge_n, pulses);
        check("s3a_done_edge", 32'(edge_n), 32'd17);
        check("s3a_pulses", 32'(pulses), 32'd1);
        check_res1("s3a", 8'h94, 8'h09, 8'h9D, 5'd0, 1'b0, 3'd0, 1'b1);

        // Scenario 3b: start re-pulsed at edge 5 is ignored.
        kick(1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1'b0, edge_n, pulses);
        check("s3b_done_edge", 32'(edge_n + 5), 32'd17);
        check("s3b_pulses", 32'(pulses), 32'd1);
        check_res1("s3b", 8'h94, 8'h09, 8'h9D, 5'd0, 1'b0, 3'd0, 1'b1);

        // Scenario 4: reset mid-sweep after edge 9 (idx 0..3 sampled).
        kick(1'b0, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        check("s4_busy_pre", 32'(busy1), 32'd1);
        check("s4_tt_f1_pre", 32'(tt1_f1), 32'h04);
        check("s4_tt_f3_pre", 32'(tt1_f3), 32'h0D);
        #2;
        rst_n = 1'b0;
        #1;
        check("s4_busy_rst", 32'(busy1), 32'd0);
        check("s4_inp_rst", 32'(inp1), 32'd0);
        check("s4_tt_rst", 32'({tt1_f1, tt1_f2, tt1_f3}), 32'd0);
        pulses = 0;
        repeat (3) begin @(posedge clk); #1; if (done1) pulses++; end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (done1) pulses++; end
        check("s4_no_done", 32'(pulses), 32'd0);
        kick(1'b0, 1'b0);
        wait_done(1'b0, edge_n, pulses);
        check("s4_done_edge", 32'(edge_n), 32'd17);
        check_res1("s4", 8'h94, 8'h09, 8'h9D, 5'd0, 1'b0, 3'd0, 1'b1);

        // Scenario 5: SETTLE_CYCLES=0 instance steps inp every cycle.
        kick(1'b1, 1'b0);
        check("s5_inp_e0", 32'(inp0), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check("s5_inp_step", 32'(inp0), 32'(k));
        end
        @(posedge clk); #1;
        check("s5_busy_e8", 32'(busy0), 32'd0);
        check("s5_done_e8", 32'(done0), 32'd0);
        @(posedge clk); #1;
        check("s5_done_e9", 32'(done0), 32'd1);
        @(posedge clk); #1;
        check("s5_done_e10", 32'(done0), 32'd0);
        check("s5_tt", 32'({tt0_f1, tt0_f2, tt0_f3}), 32'h94099D);
        check("s5_err", 32'({err0, fev0, fei0}), 32'd0);
        check("s5_pass", 32'(pass0), 32'd1);

        // Scenario 6: f1 stuck at 1 (0x94 has five zero bits).
        force_f1_one = 1'b1;
        kick(1'b0, 1'b0);
        wait_done(1'b0, edge_n, pulses);
`ifdef SWEEP_STOP_ON_ERR_EN
        check("s6_done_edge", 32'(edge_n), 32'd3);
        check_res1("s6", 8'h01, 8'h01, 8'h01, 5'd1, 1'b1, 3'd0, 1'b0);
`else
        check("s6_done_edge", 32'(edge_n), 32'd17);
        check_res1("s6", 8'hFF, 8'h09, 8'h9D, 5'd5, 1'b1, 3'd0, 1'b0);
`endif
        force_f1_one = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
